// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit.
//   - funct3 size/sign encodings used by the core
//   - FSM state type (also exported on the debug port)
//   - helpers for lane-offset width and access size in bytes
package lsu_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_D  = 3'b011;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;
  localparam logic [2:0] F3_WU = 3'b110;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } lsu_state_e;

  // Number of address bits that select a byte lane within one bus word.
  function automatic int lane_off_w(input int data_w);
    return $clog2(data_w / 8);
  endfunction

  // funct3[1:0] encodes log2 of the access size in bytes.
  function automatic int size_bytes(input logic [1:0] sz);
    return 1 << sz;
  endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// Combinational byte-lane steering for the load/store unit.
// Ports:
//   we, funct3, offset : captured operation (offset = byte lane of addr)
//   wdata              : right-aligned store data
//   rdata_raw          : raw bus read data
//   be                 : byte enables (size mask << offset on stores, all ones on loads)
//   wdata_rep          : store data replicated across every lane
//   rdata_ext          : load data shifted down, truncated and sign/zero extended
module lsu_lane_align import lsu_pkg::*; #(
  parameter int DATA_W = 32,
  localparam int NB    = DATA_W / 8,
  localparam int OFF_W = lane_off_w(DATA_W)
) (
  input  logic              we,
  input  logic [2:0]        funct3,
  input  logic [OFF_W-1:0]  offset,
  input  logic [DATA_W-1:0] wdata,
  input  logic [DATA_W-1:0] rdata_raw,
  output logic [NB-1:0]     be,
  output logic [DATA_W-1:0] wdata_rep,
  output logic [DATA_W-1:0] rdata_ext
);

  int                nbytes;
  logic [NB-1:0]     size_mask;
  logic [DATA_W-1:0] shifted;
  logic              msb;
  logic              sign;

  always_comb begin
    nbytes    = size_bytes(funct3[1:0]);
    size_mask = '0;
    for (int i = 0; i < NB; i++) size_mask[i] = (i < nbytes);
    be = we ? (size_mask << offset) : '1;

    // Each lane takes the store byte it would hold if the access were
    // aligned at that lane, so the memory only needs the byte enables.
    wdata_rep = '0;
    for (int i = 0; i < NB; i++) begin
      case (funct3[1:0])
        2'b00:   wdata_rep[8*i +: 8] = wdata[7:0];
        2'b01:   wdata_rep[8*i +: 8] = wdata[8*(i%2) +: 8];
        2'b10:   wdata_rep[8*i +: 8] = wdata[8*(i%4) +: 8];
        default: wdata_rep[8*i +: 8] = wdata[8*i +: 8];
      endcase
    end

    shifted = rdata_raw >> {offset, 3'b000};
    case (funct3[1:0])
      2'b00:   msb = shifted[7];
      2'b01:   msb = shifted[15];
      2'b10:   msb = shifted[31];
      default: msb = shifted[DATA_W-1];
    endcase
    // funct3[2] selects the unsigned variants.
    sign = msb & ~funct3[2];
    rdata_ext = '0;
    for (int j = 0; j < DATA_W; j++) rdata_ext[j] = (j < 8*nbytes) ? shifted[j] : sign;
  end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit between the core datapath and a variable-latency memory.
// Ports:
//   clk, rst (async, active low)
//   core side : request, we, funct3, addr, wdata -> rdata, stall, done, err
//   bus side  : mem_req, mem_we, mem_addr, mem_wdata, mem_be <- mem_ack, mem_rdata
//   dbg_state : current FSM state
// Handshake: the core holds request (and its operands) until done; the bus
// holds mem_req with stable mem_* until one cycle of mem_ack, which
// qualifies mem_rdata. done is a one-cycle pulse; err is valid only with done.
module load_store_unit import lsu_pkg::*; #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  request,
  input  logic                  we,
  input  logic [2:0]            funct3,
  input  logic [ADDR_W-1:0]     addr,
  input  logic [DATA_W-1:0]     wdata,
  output logic [DATA_W-1:0]     rdata,
  output logic                  stall,
  output logic                  done,
  output logic                  err,
  output logic                  mem_req,
  output logic                  mem_we,
  output logic [ADDR_W-1:0]     mem_addr,
  output logic [DATA_W-1:0]     mem_wdata,
  output logic [DATA_W/8-1:0]   mem_be,
  input  logic                  mem_ack,
  input  logic [DATA_W-1:0]     mem_rdata,
  output lsu_state_e            dbg_state
);

  localparam int NB    = DATA_W / 8;
  localparam int OFF_W = lane_off_w(DATA_W);
  localparam int CNT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

  lsu_state_e        state;
  logic              cap_we;
  logic [2:0]        cap_f3;
  logic [OFF_W-1:0]  cap_off;
  logic [ADDR_W-1:0] cap_addr;
  logic [DATA_W-1:0] cap_wdata;
  logic [CNT_W-1:0]  tcount;

  logic              f3_legal;
  logic              aligned;
  logic              timeout_hit;
  logic              busy;
  logic [NB-1:0]     al_be;
  logic [DATA_W-1:0] al_wdata;
  logic [DATA_W-1:0] al_rdata;

  always_comb begin
    case (funct3)
      F3_D, F3_WU: f3_legal = (DATA_W == 64);
      3'b111:      f3_legal = 1'b0;
      default:     f3_legal = 1'b1;
    endcase
    case (funct3[1:0])
      2'b00:   aligned = 1'b1;
      2'b01:   aligned = ~addr[0];
      2'b10:   aligned = (addr[1:0] == 2'b00);
      default: aligned = (addr[2:0] == 3'b000);
    endcase
  end

  // This BUSY cycle is the TIMEOUT-th one without an ack.
  assign timeout_hit = (TIMEOUT != 0) && ((32'(tcount) + 32'd1) == 32'(TIMEOUT));

  lsu_lane_align #(.DATA_W(DATA_W)) u_align (
    .we        (cap_we),
    .funct3    (cap_f3),
    .offset    (cap_off),
    .wdata     (cap_wdata),
    .rdata_raw (mem_rdata),
    .be        (al_be),
    .wdata_rep (al_wdata),
    .rdata_ext (al_rdata)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= ST_IDLE;
      cap_we    <= 1'b0;
      cap_f3    <= '0;
      cap_off   <= '0;
      cap_addr  <= '0;
      cap_wdata <= '0;
      tcount    <= '0;
      rdata     <= '0;
      err       <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (request) begin
            if (f3_legal && aligned) begin
              cap_we    <= we;
              cap_f3    <= funct3;
              cap_off   <= addr[OFF_W-1:0];
              cap_addr  <= {addr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
              cap_wdata <= wdata;
              tcount    <= '0;
              state     <= ST_BUSY;
            end else begin
              // Rejected ops never reach the bus.
              err   <= 1'b1;
              rdata <= '0;
              state <= ST_DONE;
            end
          end
        end
        ST_BUSY: begin
          // Ack takes priority over a timeout landing on the same cycle.
          if (mem_ack) begin
            rdata <= cap_we ? '0 : al_rdata;
            err   <= 1'b0;
            state <= ST_DONE;
          end else if (timeout_hit) begin
            rdata <= '0;
            err   <= 1'b1;
            state <= ST_DONE;
          end else begin
            tcount <= tcount + CNT_W'(1);
          end
        end
        ST_DONE: begin
          // request may still be high here; it belongs to the finished op.
          err   <= 1'b0;
          state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign busy      = (state == ST_BUSY);
  assign done      = (state == ST_DONE);
  assign dbg_state = state;
  // Gated by rst so the core is released the moment reset asserts.
  assign stall     = rst & (((state == ST_IDLE) & request) | busy);

  assign mem_req   = busy;
  assign mem_we    = busy & cap_we;
  assign mem_addr  = busy ? cap_addr : '0;
  assign mem_wdata = busy ? al_wdata : '0;
  assign mem_be    = busy ? al_be    : '0;

endmodule
